fp_sort_engine: RTL

// - Multi-cycle, parametrised magnitude sorter for IEEE-754 operands; N-operand successor to the two-operand big/small sort.
// - Loads N floats over a valid/ready stream and sorts them by |x| with an odd-even transposition network, N/2 comparators per pass.
// - Streams the sorted operands out with their original arrival index; feeds multi-operand accumulation ahead of the FP adder.

---
 rtl/fp_pkg.sv | 13 +
 rtl/fp_mag_cmp.sv | 14 +
 rtl/fp_sort_engine.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: default field widths and the sort engine's FSM states.
package fp_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;

  typedef enum logic [1:0] {
    SORT_LOAD,
    SORT_RUN,
    SORT_DRAIN
  } sort_state_e;

endpackage

// File: rtl/fp_mag_cmp.sv
// Strict magnitude comparator for IEEE-754 operands; the sign is ignored and {exp,frac} compared unsigned.
module fp_mag_cmp #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  output logic                  a_gt_b
);

  // Exp sits above frac, so one unsigned compare orders exp first; raw bits put NaN above Inf.
  assign a_gt_b = a[EXP_W+FRAC_W-1:0] > b[EXP_W+FRAC_W-1:0];

endmodule

// File: rtl/fp_sort_engine.sv
// N-operand magnitude sorter: load over valid/ready, N passes of odd-even transposition, stream out with arrival index.
module fp_sort_engine
  import fp_pkg::*;
#(
  parameter int  EXP_W   = FP_EXP_W,
  parameter int  FRAC_W  = FP_FRAC_W,
  parameter int  N       = 8,
  parameter bit  DESCEND = 1'b1,
  localparam int W       = 1 + EXP_W + FRAC_W,
  localparam int IDX_W   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

  typedef struct packed {
    logic [W-1:0]     data;
    logic [IDX_W-1:0] idx;
  } elem_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  sort_state_e      state_q, state_d;
  elem_t            mem_q  [N];
  elem_t            sorted [N];
  logic [IDX_W-1:0] wr_cnt_q, pass_q, rd_ptr_q;
  logic [N-2:0]     ooo;
  logic             in_beat, out_beat;

  // ooo[k]: pair (k,k+1) is strictly out of order; ties never swap, which keeps the sort stable.
  for (genvar k = 0; k < N - 1; k++) begin : gen_cmp
    if (DESCEND) begin : g_desc
      fp_mag_cmp #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cmp (
        .a(mem_q[k+1].data), .b(mem_q[k].data), .a_gt_b(ooo[k]));
    end else begin : g_asc
      fp_mag_cmp #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cmp (
        .a(mem_q[k].data), .b(mem_q[k+1].data), .a_gt_b(ooo[k]));
    end
  end

  // Even passes use pairs starting at even k, odd passes at odd k; pairs in one pass never overlap.
  always_comb begin
    sorted = mem_q;
    for (int k = 0; k < N - 1; k++) begin
      if (ooo[k] && ((k % 2) == int'(pass_q[0]))) begin
        sorted[k]   = mem_q[k+1];
        sorted[k+1] = mem_q[k];
      end
    end
  end

  assign in_beat  = in_valid && in_ready;
  assign out_beat = out_valid && out_ready;
  assign out_data = mem_q[rd_ptr_q].data;
  assign out_idx  = mem_q[rd_ptr_q].idx;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      SORT_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_beat && wr_cnt_q == LAST) state_d = SORT_RUN;
      end
      SORT_RUN: begin
        if (pass_q == LAST) state_d = SORT_DRAIN;
      end
      SORT_DRAIN: begin
        out_valid = 1'b1;
        out_last  = (rd_ptr_q == LAST);
        if (out_valid && out_ready && out_last) state_d = SORT_LOAD;
      end
      default: state_d = SORT_LOAD;
    endcase
  end

  // NOTE: the element buffer is deliberately cleared by reset so a fresh set never sees stale data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= SORT_LOAD;
      wr_cnt_q <= '0;
      pass_q   <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        SORT_LOAD: begin
          if (in_beat) begin
            mem_q[wr_cnt_q] <= '{data: in_data, idx: wr_cnt_q};
            wr_cnt_q        <= (wr_cnt_q == LAST) ? '0 : wr_cnt_q + ONE;
          end
        end
        SORT_RUN: begin
          mem_q    <= sorted;
          pass_q   <= (pass_q == LAST) ? '0 : pass_q + ONE;
          rd_ptr_q <= '0;
        end
        SORT_DRAIN: begin
          if (out_beat) rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + ONE;
        end
        default: ;
      endcase
    end
  end

endmodule
